nios_pio_gpio_edge: RTL

//  Parametrised Avalon-MM general-purpose PIO for the Nios system: WIDTH-bit bidirectional port.

---
 rtl/nios_pio_gpio_edge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nios_pio_gpio_edge.sv
// nios_pio_gpio_edge
//   Avalon-MM s1 general-purpose PIO for the Nios data master. WIDTH-bit port
//   with per-bit direction, atomic set/clear writes, synchronised inputs,
//   edge capture and a maskable, registered level interrupt. Reads have a
//   1-cycle latency.
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   address[2:0]      word address
//   chipselect        slave select
//   read_n, write_n   active-low read/write strobes
//   writedata[31:0]   write data (bits above WIDTH ignored)
//   readdata[31:0]    registered read data (bits above WIDTH are 0)
//   in_port[WIDTH]    asynchronous pin inputs
//   out_port[WIDTH]   data_out register
//   oe[WIDTH]         direction register (1 = drive pin)
//   irq               registered |(edge_capture & irq_mask)

// Per-bit input lane: synchroniser, previous-value flop, edge detect and the
// sticky capture bit with write-1-to-clear (a simultaneous edge wins).
module nios_pio_gpio_edge_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic capture_en,
  input  logic clr,
  output logic in_sync,
  output logic cap
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_hit;

  assign in_sync = sync[SYNC_STAGES-1];

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_TYPE)
      0:       edge_hit =  in_sync & ~prev;
      1:       edge_hit = ~in_sync &  prev;
      default: edge_hit =  in_sync ^  prev;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
      cap  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      prev <= in_sync;
      // Set term is OR-ed in after the clear so a colliding edge is kept.
      cap  <= (cap & ~clr) | (edge_hit & capture_en);
    end
  end
endmodule

module nios_pio_gpio_edge #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  localparam int GUARD = SYNC_STAGES + 1;
  localparam int GW    = $clog2(SYNC_STAGES + 2);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic             wr, rd;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out, dir, mask;
  logic [WIDTH-1:0] in_sync, edgecap, clr;
  logic [WIDTH-1:0] rsel;
  logic [GW-1:0]    guard_cnt;
  logic             guard_done;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & ~read_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign out_port  = data_out;
  assign oe        = dir;
  assign clr       = (wr && address == A_EDGE) ? wd : '0;

  // Startup guard: the sync chain resets to 0, so pins already high would
  // look like rising edges until the chain and prev have filled.
  assign guard_done = (guard_cnt == GW'(GUARD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        guard_cnt <= '0;
    else if (!guard_done) guard_cnt <= guard_cnt + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_pio_gpio_edge_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin        (in_port[i]),
      .capture_en (guard_done),
      .clr        (clr[i]),
      .in_sync    (in_sync[i]),
      .cap        (edgecap[i])
    );
  end

  // Read mux uses current (pre-write) register values.
  always_comb begin
    rsel = '0;
    case (address)
      A_DATA:  rsel = (dir & data_out) | (~dir & in_sync);
      A_DIR:   rsel = dir;
      A_MASK:  rsel = mask;
      A_EDGE:  rsel = edgecap;
      default: rsel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      mask     <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd) readdata <= 32'(rsel);
      if (wr) begin
        case (address)
          A_DATA:   data_out <= wd;
          A_DIR:    dir      <= wd;
          A_MASK:   mask     <= wd;
          A_OUTSET: data_out <= data_out | wd;
          A_OUTCLR: data_out <= data_out & ~wd;
          default:  ;
        endcase
      end
      irq <= |(edgecap & mask);
    end
  end
endmodule
